// File: rtl/button_press_capture.sv
// ---------------------------------------------------------------------------
// button_press_capture
//
// Turns a raw push-button into a processor-readable event register. The raw
// level is synchronized (2 flops), debounced, and every accepted press sets
// a sticky pending flag and bumps a saturating press counter. The processor
// reads the event word on buttonPressed and acknowledges it by writing
// register ACK_REG through the regfile write port (zero data also clears
// the counter).
//
// Optional build macro: LIGHT_TOGGLE_EN
//   defined   : light is a toggle flop inverted on every accepted press
//   undefined : light follows the debounced button level
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples to accept a
//                     level change (>= 1)
//   CNT_WIDTH       : press counter width (1..15)
//   ACK_REG         : regfile index whose write acknowledges the event
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous active-high reset
//   button_raw       in   asynchronous raw button level, 1 = pressed
//   ctrl_writeEnable in   regfile write enable
//   ctrl_writeReg    in   [4:0] regfile write index
//   data_writeReg    in   [31:0] regfile write data
//   buttonPressed    out  [31:0] {pending, zeros, press_count}
//   light            out  indicator LED
//   press_pulse      out  one-cycle strobe per accepted press
// ---------------------------------------------------------------------------
module button_press_capture #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         CNT_WIDTH       = 8,
    parameter logic [4:0] ACK_REG         = 5'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        button_raw,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,
    output logic [31:0] buttonPressed,
    output logic        light,
    output logic        press_pulse
);

    localparam int                   DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]      DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_deb;
    logic [DB_W-1:0]      r_db_cnt;
    logic [CNT_WIDTH-1:0] r_press_count;
    logic                 r_pending;
    logic                 r_press_pulse;

    logic                 w_mismatch;
    logic                 w_settle;
    logic                 w_accept;
    logic                 w_ack;
    logic                 w_ack_clear;
    logic [CNT_WIDTH-1:0] w_count_next;
    logic                 w_pending_next;

    // Debounce decisions: a level change is taken only after the synchronized
    // input has disagreed with the debounced level for DEBOUNCE_CYCLES edges.
    assign w_mismatch  = (r_sync2 != r_deb);
    assign w_settle    = w_mismatch && (r_db_cnt == DB_LAST);
    assign w_accept    = w_settle && r_sync2;   // only the 0->1 change is a press

    assign w_ack       = ctrl_writeEnable && (ctrl_writeReg == ACK_REG) && (ACK_REG != 5'd0);
    assign w_ack_clear = w_ack && (data_writeReg == 32'd0);

    // A press accepted on the same edge as an ack wins: the event stays
    // pending, and a clearing ack leaves exactly this one press counted.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_count_next   = r_press_count;
        w_pending_next = r_pending;
        if (w_accept) begin
            w_pending_next = 1'b1;
            if (w_ack_clear)
                w_count_next = CNT_WIDTH'(1);
            else if (r_press_count != CNT_MAX)
                w_count_next = r_press_count + CNT_WIDTH'(1);
        end else if (w_ack) begin
            w_pending_next = 1'b0;
            if (w_ack_clear)
                w_count_next = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops sample the old values together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= button_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_deb    <= 1'b0;
            r_db_cnt <= '0;
        end else if (!w_mismatch) begin
            r_db_cnt <= '0;
        end else if (w_settle) begin
            r_deb    <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_press_count <= '0;
            r_pending     <= 1'b0;
            r_press_pulse <= 1'b0;
        end else begin
            r_press_count <= w_count_next;
            r_pending     <= w_pending_next;
            r_press_pulse <= w_accept;
        end
    end

`ifdef LIGHT_TOGGLE_EN
    logic r_light;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_light <= 1'b0;
        else if (w_accept)
            r_light <= ~r_light;
    end

    assign light = r_light;
`else
    assign light = r_deb;
`endif

    // Output word is built only from registered state.
    assign buttonPressed = {r_pending, {(31-CNT_WIDTH){1'b0}}, r_press_count};
    assign press_pulse   = r_press_pulse;

endmodule

// File: tb/tb_button_press_capture.sv
// ---------------------------------------------------------------------------
// tb_button_press_capture
//
// Directed and randomized bench for button_press_capture. Two instances run
// side by side on the same stimulus: the default configuration and one with
// CNT_WIDTH=2 for counter saturation. Expected values come from a reference
// model that works on the history of sampled button levels: the debounced
// level flips when the last DEBOUNCE_CYCLES synchronized samples all differ
// from it, and the synchronized sample is the raw level from two edges ago.
// Build with +define+LIGHT_TOGGLE_EN to check the toggle-light variant.
// ---------------------------------------------------------------------------
module tb_button_press_capture;

    localparam int DC   = 4;
    localparam int MAX1 = 255;
    localparam int MAX2 = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        button_raw;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;

    logic [31:0] bp1, bp2;
    logic        light1, light2;
    logic        pulse1, pulse2;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit raw_hist[$];
    bit s2_hist[$];
    bit deb_m, pend_m, pulse_m, light_m;
    int cnt1_m, cnt2_m;

    always #5 clock = ~clock;

    button_press_capture #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(8), .ACK_REG(5'd2)) dut (
        .clock(clock), .reset(reset), .button_raw(button_raw),
        .ctrl_writeEnable(we), .ctrl_writeReg(wreg), .data_writeReg(wdata),
        .buttonPressed(bp1), .light(light1), .press_pulse(pulse1)
    );

    button_press_capture #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(2), .ACK_REG(5'd2)) dut_sat (
        .clock(clock), .reset(reset), .button_raw(button_raw),
        .ctrl_writeEnable(we), .ctrl_writeReg(wreg), .data_writeReg(wdata),
        .buttonPressed(bp2), .light(light2), .press_pulse(pulse2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int cnt);
        logic [31:0] w;
        w     = 32'(cnt);
        w[31] = pend_m;
        return w;
    endfunction

    function automatic logic light_exp();
`ifdef LIGHT_TOGGLE_EN
        return light_m;
`else
        return deb_m;
`endif
    endfunction

    task automatic model_reset();
        raw_hist.delete();
        s2_hist.delete();
        deb_m   = 1'b0;
        pend_m  = 1'b0;
        pulse_m = 1'b0;
        light_m = 1'b0;
        cnt1_m  = 0;
        cnt2_m  = 0;
    endtask

    task automatic model_edge();
        bit s2, flip, accept, ack, clr;
        int n;
        n  = raw_hist.size();
        s2 = (n >= 2) ? raw_hist[n-2] : 1'b0;
        s2_hist.push_back(s2);
        flip = (s2_hist.size() >= DC);
        if (flip)
            for (int i = 1; i <= DC; i++)
                if (s2_hist[s2_hist.size()-i] == deb_m) flip = 1'b0;
        accept = flip && !deb_m;
        ack    = we && (wreg == 5'd2);
        clr    = ack && (wdata == 32'd0);
        if (accept) begin
            pend_m  = 1'b1;
            light_m = ~light_m;
            cnt1_m  = clr ? 1 : ((cnt1_m < MAX1) ? cnt1_m + 1 : MAX1);
            cnt2_m  = clr ? 1 : ((cnt2_m < MAX2) ? cnt2_m + 1 : MAX2);
        end else if (ack) begin
            pend_m = 1'b0;
            if (clr) begin
                cnt1_m = 0;
                cnt2_m = 0;
            end
        end
        if (flip) deb_m = ~deb_m;
        pulse_m = accept;
        raw_hist.push_back(button_raw);
    endtask

    task automatic check_all(input string ph);
        check({ph, ".word"},    bp1,           word_of(cnt1_m));
        check({ph, ".pulse"},   32'(pulse1),   32'(pulse_m));
        check({ph, ".light"},   32'(light1),   32'(light_exp()));
        check({ph, ".word2"},   bp2,           word_of(cnt2_m));
        check({ph, ".pulse2"},  32'(pulse2),   32'(pulse_m));
        check({ph, ".light2"},  32'(light2),   32'(light_exp()));
    endtask

    // One clock edge: model follows the edge, outputs compared on the falling edge.
    task automatic tick(input string ph);
        @(posedge clock);
        if (!reset) model_edge();
        @(negedge clock);
        check_all(ph);
    endtask

    task automatic ticks(input int n, input string ph);
        repeat (n) tick(ph);
    endtask

    // Reset asserted between edges: outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic press(input string ph);
        button_raw = 1'b1;
        ticks(8, ph);
        button_raw = 1'b0;
        ticks(8, ph);
    endtask

    task automatic reg_write(input logic [4:0] r, input logic [31:0] d, input string ph);
        we    = 1'b1;
        wreg  = r;
        wdata = d;
        tick(ph);
        we    = 1'b0;
        wreg  = 5'd0;
        wdata = 32'd0;
    endtask

    initial begin
        int run;
        reset      = 1'b1;
        button_raw = 1'b0;
        we         = 1'b0;
        wreg       = 5'd0;
        wdata      = 32'd0;
        @(negedge clock);
        model_reset();
        check_all("reset");
        check("reset.word_const", bp1, 32'h0);
        reset = 1'b0;

        // Held button: accepted at the sixth edge.
        button_raw = 1'b1;
        ticks(5, "latency");
        check("latency.no_pulse_e5", 32'(pulse1), 32'd0);
        tick("latency");
        check("latency.pulse_e6", 32'(pulse1), 32'd1);
        check("latency.word_e6", bp1, 32'h8000_0001);
        check("latency.light_e6", 32'(light1), 32'd1);
        tick("latency");
        check("latency.pulse_e7", 32'(pulse1), 32'd0);
        button_raw = 1'b0;
        ticks(10, "release");

        // Two-cycle glitch is rejected.
        do_reset();
        button_raw = 1'b1;
        ticks(2, "glitch");
        button_raw = 1'b0;
        ticks(10, "glitch");
        check("glitch.word", bp1, 32'h0);
        check("glitch.light", 32'(light1), 32'd0);

        // Three presses, then acks with nonzero and zero data.
        do_reset();
        repeat (3) press("three");
        check("three.word", bp1, 32'h8000_0003);
        reg_write(5'd2, 32'd5, "ack_keep");
        check("ack_keep.word", bp1, 32'h0000_0003);
        reg_write(5'd2, 32'd0, "ack_clear");
        check("ack_clear.word", bp1, 32'h0000_0000);

        // Clearing ack on the accept edge: the press wins.
        do_reset();
        button_raw = 1'b1;
        ticks(5, "race");
        reg_write(5'd2, 32'd0, "race");
        check("race.word", bp1, 32'h8000_0001);
        check("race.pulse", 32'(pulse1), 32'd1);
        reg_write(5'd3, 32'd0, "other_reg");
        check("other_reg.word", bp1, 32'h8000_0001);
        button_raw = 1'b0;
        ticks(8, "race");

        // Saturation on the 2-bit counter instance.
        do_reset();
        repeat (5) press("sat");
        check("sat.word2", bp2, 32'h8000_0003);
        check("sat.word", bp1, 32'h8000_0005);

        // Reset in the middle of debounce, button kept held.
        do_reset();
        press("mid");
        button_raw = 1'b1;
        ticks(4, "mid");
        do_reset();
        check("mid.word_async", bp1, 32'h0);
        ticks(5, "mid_rel");
        check("mid_rel.no_pulse_e5", 32'(pulse1), 32'd0);
        tick("mid_rel");
        check("mid_rel.pulse_e6", 32'(pulse1), 32'd1);
        check("mid_rel.word_e6", bp1, 32'h8000_0001);
        button_raw = 1'b0;
        ticks(8, "mid_rel");

        // Randomized runs of button levels with sporadic register writes.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            button_raw = 1'($urandom_range(0, 1));
            run        = $urandom_range(1, 10);
            repeat (run) begin
                if ($urandom_range(0, 7) == 0) begin
                    we = 1'b1;
                    case ($urandom_range(0, 3))
                        0:       wreg = 5'd2;
                        1:       wreg = 5'd3;
                        2:       wreg = 5'd0;
                        default: wreg = 5'($urandom);
                    endcase
                    wdata = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom);
                end else begin
                    we    = 1'b0;
                    wreg  = 5'd0;
                    wdata = 32'd0;
                end
                tick("random");
            end
        end
        we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
